// File: rtl/cpu_pkg.sv
// Shared types and defaults for the core's memory-side blocks.
package cpu_pkg;

    // Consecutive data grants allowed against a pending fetch before fetch is forced
    localparam int unsigned ARB_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_WAIT_GNT  = 2'd1,
        ARB_WAIT_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing one unified memory between fetch and the MEM stage.
// One transaction outstanding at a time; data has priority, bounded by a
// starvation counter; an accepted fetch can be killed on redirect.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t        state_q,  state_d;
    arb_owner_t        owner_q,  owner_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              we_q,     we_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              kill_q,   kill_d;
    logic              if_rvalid_d;
    logic              d_rvalid_d;
    logic              resp_take;
    logic              fetch_forced;

    // Fetch must win once data has beaten a pending fetch STARVE_MAX times in a row
    assign fetch_forced = if_req && (starve_q == CNT_MAX);

    // Latched transaction fields drive the memory side directly
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Next-state, arbitration and handshake decode
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        starve_d    = starve_q;
        kill_d      = kill_q;
        if_ready    = 1'b0;
        d_ready     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        resp_take   = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (d_req && !fetch_forced) begin
                    d_ready = 1'b1;
                    owner_d = OWN_D;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    state_d = ARB_WAIT_GNT;
                    // Cannot overflow: at CNT_MAX with if_req pending, data does not win
                    starve_d = if_req ? starve_q + CNT_W'(1) : '0;
                end else if (if_req) begin
                    if_ready = 1'b1;
                    owner_d  = OWN_IF;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    we_d     = 1'b0;
                    starve_d = '0;
                    state_d  = ARB_WAIT_GNT;
                end
            end
            ARB_WAIT_GNT: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                if (if_kill && owner_q == OWN_IF) kill_d = 1'b1;
                if (mem_gnt) state_d = we_q ? ARB_IDLE : ARB_WAIT_RESP;
            end
            ARB_WAIT_RESP: begin
                if (if_kill && owner_q == OWN_IF) kill_d = 1'b1;
                if (mem_rvalid) begin
                    resp_take = 1'b1;
                    state_d   = ARB_IDLE;
                    if (owner_q == OWN_IF) if_rvalid_d = !(kill_q || if_kill);
                    else                   d_rvalid_d  = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Kill only ever applies to the fetch currently in flight
        if (state_d == ARB_IDLE) kill_d = 1'b0;
    end

    // FSM state and transaction context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_IF;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            starve_q <= '0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            starve_q <= starve_d;
            kill_q   <= kill_d;
        end
    end

    // Registered read responses toward the requesters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= if_rvalid_d;
            d_rvalid  <= d_rvalid_d;
            if (resp_take) begin
                if (owner_q == OWN_IF) if_rdata <= mem_rdata;
                else                   d_rdata  <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference of the arbitration and memory contents.
module tb_mem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int          SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_kill, if_ready, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ready, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    // Memory model controls
    bit            mem_auto = 1'b0;
    bit            mem_rand = 1'b0;
    int            gnt_dly  = 0;
    int            rsp_dly  = 0;
    logic          auto_gnt, auto_rvalid, man_gnt, man_rvalid;
    logic [DW-1:0] auto_rdata, man_rdata;
    int            stab_bad;

    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] ref_mem [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign mem_gnt    = mem_auto ? auto_gnt    : man_gnt;
    assign mem_rvalid = mem_auto ? auto_rvalid : man_rvalid;
    assign mem_rdata  = mem_auto ? auto_rdata  : man_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(int i);
        if (i == 4)          return 32'h0000_0013;
        else if (i == 'h80)  return 32'hCAFE_0200;
        else                 return {16'hA5A5, 16'(i)};
    endfunction

    // Memory responder: grant after gnt delay, return read data after rsp delay
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_w;
    logic          r_we;
    int            r_gd, r_rd;
    initial begin
        auto_gnt = 1'b0; auto_rvalid = 1'b0; auto_rdata = '0; stab_bad = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
        forever begin
            @(negedge clk);
            auto_gnt = 1'b0; auto_rvalid = 1'b0; auto_rdata = DW'($urandom);
            if (mem_auto && rst_n && mem_req) begin
                r_a = mem_addr; r_w = mem_wdata; r_we = mem_we;
                r_gd = mem_rand ? int'($urandom_range(0, 3)) : gnt_dly;
                r_rd = mem_rand ? int'($urandom_range(0, 3)) : rsp_dly;
                for (int i = 0; i < r_gd; i++) begin
                    @(negedge clk);
                    if (mem_req !== 1'b1 || mem_addr !== r_a || mem_we !== r_we || mem_wdata !== r_w)
                        stab_bad++;
                end
                auto_gnt = 1'b1;
                @(negedge clk);
                auto_gnt = 1'b0;
                if (r_we) mem_arr[r_a[9:2]] = r_w;
                else begin
                    repeat (r_rd) @(negedge clk);
                    auto_rvalid = 1'b1;
                    auto_rdata  = mem_arr[r_a[9:2]];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({if_ready, d_ready, if_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {if_ready, d_ready, if_rvalid, d_rvalid, mem_req, mem_we});
        end
        tests++;
        if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h wdata=%h ird=%h drd=%h expected all 0",
                     mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        rst_n = 1'b1;
        mem_auto = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        gnt_dly = 0; rsp_dly = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0010; #1;
        tests++;
        if (if_ready !== 1'b1 || d_ready !== 1'b0) begin
            fails++; $display("FAIL fetch_accept: got if_ready=%b d_ready=%b expected 1 0", if_ready, d_ready);
        end
        @(negedge clk); if_req = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
            fails++; $display("FAIL fetch_memreq: got req=%b we=%b addr=%h expected 1 0 00000010", mem_req, mem_we, mem_addr);
        end
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0 || if_rvalid !== 1'b0) begin
            fails++; $display("FAIL fetch_wait: got req=%b rvalid=%b expected 0 0", mem_req, if_rvalid);
        end
        @(negedge clk);
        tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h0000_0013) begin
            fails++; $display("FAIL fetch_resp: got rvalid=%b rdata=%h expected 1 00000013", if_rvalid, if_rdata);
        end
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_03F0; d_wdata = 32'h1111_2222; #1;
        tests++;
        if (d_ready !== 1'b1) begin
            fails++; $display("FAIL fetch_next_accept: got d_ready=%b expected 1", d_ready);
        end
        ref_mem[8'hFC] = 32'h1111_2222;
        @(negedge clk); d_req = 1'b0;
        tests++;
        if (if_rvalid !== 1'b0) begin
            fails++; $display("FAIL fetch_pulse: got if_rvalid=%b expected 0", if_rvalid);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_store();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; #1;
        tests++;
        if (d_ready !== 1'b1) begin
            fails++; $display("FAIL store_accept: got d_ready=%b expected 1", d_ready);
        end
        ref_mem[8'h40] = 32'hDEAD_BEEF;
        @(negedge clk); d_req = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL store_memreq: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000100 deadbeef",
                              mem_req, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0010; #1;
        tests++;
        if (d_rvalid !== 1'b0 || if_ready !== 1'b1) begin
            fails++; $display("FAIL store_idle: got d_rvalid=%b if_ready=%b expected 0 1", d_rvalid, if_ready);
        end
        @(negedge clk); if_req = 1'b0;
        tests++;
        if (d_rvalid !== 1'b0) begin
            fails++; $display("FAIL store_no_resp: got d_rvalid=%b expected 0", d_rvalid);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_starve();
        bit got [10];
        int n = 0;
        int cyc = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0020;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h0BAD_F00D;
        ref_mem[8'hC0] = 32'h0BAD_F00D;
        while (n < 10 && cyc < 300) begin
            #1;
            if (if_ready) begin got[n] = 1'b1; n++; end
            else if (d_ready) begin got[n] = 1'b0; n++; end
            @(negedge clk); cyc++;
        end
        if_req = 1'b0; d_req = 1'b0;
        tests++;
        if (n != 10) begin
            fails++; $display("FAIL starve_timeout: got %0d grants expected 10", n);
        end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (got[i] !== ((i % (SMAX + 1)) == SMAX)) begin
                fails++; $display("FAIL starve_order[%0d]: got fetch=%b expected fetch=%b",
                                  i, got[i], ((i % (SMAX + 1)) == SMAX));
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_kill();
        int seen = 0;
        int bad_req = 0;
        int base = stab_bad;
        int waited = 0;
        gnt_dly = 3; rsp_dly = 1;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0040; #1;
        tests++;
        if (if_ready !== 1'b1) begin
            fails++; $display("FAIL kill_accept: got if_ready=%b expected 1", if_ready);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) if_req = 1'b0;
            if_kill = (k == 5);
            if (k <= 4 && mem_req !== 1'b1) bad_req++;
            if (k == 5) begin
                tests++;
                if (mem_req !== 1'b0) begin
                    fails++; $display("FAIL kill_wait_resp: got mem_req=%b expected 0", mem_req);
                end
            end
            if (if_rvalid) seen++;
        end
        if_kill = 1'b0;
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL kill_suppress: got %0d if_rvalid pulses expected 0", seen);
        end
        tests++;
        if (bad_req != 0 || stab_bad != base) begin
            fails++; $display("FAIL kill_stable: got %0d dropped req, %0d unstable cycles expected 0 0",
                              bad_req, stab_bad - base);
        end
        // A kill in IDLE must not affect a request arbitrated in the same cycle
        gnt_dly = 0; rsp_dly = 0;
        if_req = 1'b1; if_addr = 32'h0000_0010; if_kill = 1'b1; #1;
        tests++;
        if (if_ready !== 1'b1) begin
            fails++; $display("FAIL kill_idle_accept: got if_ready=%b expected 1", if_ready);
        end
        @(negedge clk); if_req = 1'b0; if_kill = 1'b0;
        while (!if_rvalid && waited < 20) begin @(negedge clk); waited++; end
        tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h0000_0013) begin
            fails++; $display("FAIL kill_idle_resp: got rvalid=%b rdata=%h expected 1 00000013", if_rvalid, if_rdata);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_load_delay();
        int pulses = 0;
        int first = -1;
        int ready_bad = 0;
        bit late_ready = 1'b0;
        logic [DW-1:0] got_data = '0;
        gnt_dly = 0; rsp_dly = 5;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0044;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; #1;
        tests++;
        if (d_ready !== 1'b1 || if_ready !== 1'b0) begin
            fails++; $display("FAIL load_accept: got d_ready=%b if_ready=%b expected 1 0", d_ready, if_ready);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) d_req = 1'b0;
            if (k == 9) if_req = 1'b0;
            if (d_rvalid) begin
                pulses++; got_data = d_rdata;
                if (first < 0) first = k;
            end
            #1;
            if (k < 8 && if_ready !== 1'b0) ready_bad++;
            if (k == 8) late_ready = if_ready;
        end
        tests++;
        if (pulses != 1 || first != 8 || got_data !== 32'hCAFE_0200) begin
            fails++; $display("FAIL load_resp: got %0d pulses first=%0d data=%h expected 1 8 cafe0200",
                              pulses, first, got_data);
        end
        tests++;
        if (ready_bad != 0 || late_ready !== 1'b1) begin
            fails++; $display("FAIL load_if_ready: got %0d early readies, ready_at_idle=%b expected 0 1",
                              ready_bad, late_ready);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rsp_dly = 0;
        @(negedge clk);
        mem_auto = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; #1;
        tests++;
        if (d_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_accept: got d_ready=%b expected 1", d_ready);
        end
        @(negedge clk); d_req = 1'b0; man_gnt = 1'b1;
        @(negedge clk); man_gnt = 1'b0;
        #2 rst_n = 1'b0; #1;
        tests++;
        if ({if_ready, d_ready, if_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0 ||
            mem_addr !== '0 || d_rdata !== '0) begin
            fails++; $display("FAIL rstmid_outputs: got ctrl=%b addr=%h drd=%h expected 0 0 0",
                              {if_ready, d_ready, if_rvalid, d_rvalid, mem_req, mem_we}, mem_addr, d_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1; man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
        @(negedge clk); man_rvalid = 1'b0;
        tests++;
        if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || d_rdata !== '0) begin
            fails++; $display("FAIL rstmid_ignore: got d_rvalid=%b if_rvalid=%b drd=%h expected 0 0 0",
                              d_rvalid, if_rvalid, d_rdata);
        end
        mem_auto = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0304; d_wdata = 32'h7777_0304; #1;
        tests++;
        if (d_ready !== 1'b1 || mem_req !== 1'b0) begin
            fails++; $display("FAIL rstmid_idle: got d_ready=%b mem_req=%b expected 1 0", d_ready, mem_req);
        end
        ref_mem[8'hC1] = 32'h7777_0304;
        @(negedge clk); d_req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        bit pend = 1'b0, pend_if = 1'b0, if_acc = 1'b0, d_acc = 1'b0, exp_d;
        logic [DW-1:0] exp_data = '0;
        int m_starve = 0;
        int base = stab_bad;
        // Fresh reset so the reference starvation count starts from zero
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        mem_rand = 1'b1;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            if (if_rvalid) begin
                tests++;
                if (!(pend && pend_if) || if_rdata !== exp_data) begin
                    fails++; $display("FAIL rand_if_resp: got %h (pending=%b fetch=%b) expected %h",
                                      if_rdata, pend, pend_if, exp_data);
                end
                pend = 1'b0;
            end
            if (d_rvalid) begin
                tests++;
                if (!(pend && !pend_if) || d_rdata !== exp_data) begin
                    fails++; $display("FAIL rand_d_resp: got %h (pending=%b fetch=%b) expected %h",
                                      d_rdata, pend, pend_if, exp_data);
                end
                pend = 1'b0;
            end
            if (if_acc) if_req = 1'b0;
            if (d_acc)  d_req  = 1'b0;
            if_acc = 1'b0; d_acc = 1'b0;
            if (cyc < 600) begin
                if (!if_req && $urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_addr = AW'($urandom_range(0, 255)) << 2;
                end
                if (!d_req && $urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                    d_addr = AW'($urandom_range(0, 255)) << 2; d_wdata = DW'($urandom);
                end
            end
            #1;
            if (if_ready || d_ready) begin
                exp_d = d_req && !(if_req && m_starve == SMAX);
                tests++;
                if ((if_ready && d_ready) || d_ready !== exp_d || pend) begin
                    fails++; $display("FAIL rand_grant: got if_ready=%b d_ready=%b busy=%b expected d_ready=%b busy=0",
                                      if_ready, d_ready, pend, exp_d);
                end
                if (d_ready) begin
                    d_acc = 1'b1;
                    m_starve = if_req ? m_starve + 1 : 0;
                    if (d_we) ref_mem[d_addr[9:2]] = d_wdata;
                    else begin pend = 1'b1; pend_if = 1'b0; exp_data = ref_mem[d_addr[9:2]]; end
                end else begin
                    if_acc = 1'b1; m_starve = 0;
                    pend = 1'b1; pend_if = 1'b1; exp_data = ref_mem[if_addr[9:2]];
                end
            end
        end
        tests++;
        if (pend || if_req || d_req) begin
            fails++; $display("FAIL rand_drain: got pending=%b if_req=%b d_req=%b expected 0 0 0", pend, if_req, d_req);
        end
        tests++;
        if (stab_bad != base) begin
            fails++; $display("FAIL rand_stable: got %0d unstable cycles expected 0", stab_bad - base);
        end
        mem_rand = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_fetch();
        test_store();
        test_starve();
        test_kill();
        test_load_delay();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the five-stage core. It lets the fetch path (pc/instr) and the MEM-stage data path (load/store address, store data, read data) share one unified instruction/data memory. It runs a three-state request/response FSM with one transaction outstanding at a time. Data accesses have fixed priority, bounded by a starvation counter that guarantees fetch progress, and in-flight fetch responses can be killed on redirect.

## Interface
Parameters:
- ADDR_W, 32, address width (byte address, passed unmodified)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants with if_req pending before fetch is forced (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address (pc)
- if_kill  in  1  discard any accepted, not-yet-returned fetch response
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (ALU result)
- d_wdata  in  DATA_W  store data
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse; load data valid (never for stores)
- d_rdata  out  DATA_W  load data
- mem_req  out  1  request to memory; held until mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid (earliest cycle after mem_gnt)
- mem_rdata  in  DATA_W  read data

## Operation
- States: IDLE, WAIT_GNT, WAIT_RESP.
- IDLE, arbitration when any request is present:
  - Data wins if d_req=1, unless if_req=1 and starve_cnt==STARVE_MAX; then fetch wins.
  - The winner's *_ready is asserted combinationally in the same cycle.
  - addr, wdata, we (we=0 for fetch) and owner are latched.
  - Next state WAIT_GNT.
- WAIT_GNT: mem_req=1 with the latched fields.
  - On mem_gnt, a write goes to IDLE with no response.
  - On mem_gnt, a read goes to WAIT_RESP.
- WAIT_RESP: mem_req=0.
  - On mem_rvalid, mem_rdata is registered into the owner's rdata, the owner's rvalid pulses the next cycle, and the state goes to IDLE.
- starve_cnt:
  - Increments (saturating) on each data grant made while if_req=1.
  - Clears on any fetch grant.
  - Clears on a data grant made with if_req=0.
- if_kill, sticky kill flag:
  - Set when if_kill=1 while owner=IF in WAIT_GNT or WAIT_RESP.
  - While the flag is set, the IF response still completes on the memory side, but if_rvalid is suppressed.
  - The flag clears on return to IDLE.
  - if_kill in IDLE has no effect. A new request presented in the same cycle as if_kill is arbitrated normally.
- Memory-side responses received outside WAIT_RESP are ignored.

## Timing
- Reset values: state IDLE, owner IF, starve_cnt 0, kill flag 0, all outputs 0.
- Reset is asynchronous, so an assertion mid-transaction aborts it: no rvalid is produced and the memory must be reset alongside.
- Read with mem_gnt in the first WAIT_GNT cycle and mem_rvalid one cycle after the grant:
  - accept at T
  - mem_req at T+1
  - mem_rvalid at T+2
  - *_rvalid at T+3
  - next accept at T+3
- Write: accept T, mem_req/mem_gnt T+1, next accept T+2.
- Back-pressure: each cycle without mem_gnt extends WAIT_GNT by one cycle, with mem_* stable. Each cycle without mem_rvalid extends WAIT_RESP.
- if_ready and d_ready are never both 1. Neither asserts outside IDLE.
- Simultaneous if_req and d_req: data wins up to STARVE_MAX times in a row, then fetch wins once.

## Structure
- Shared package cpu_pkg:
  - arb_state_t enum (ARB_IDLE, ARB_WAIT_GNT, ARB_WAIT_RESP)
  - arb_owner_t (OWN_IF, OWN_D)
  - default STARVE_MAX constant
- Single module, no sub-module; the starvation counter and kill flag are small registers inside it.

## Test plan
- Fetch of 0x0000_0010 with mem_gnt immediate and mem_rdata=0x0000_0013 one cycle later -> if_rvalid=1 at T+3 with if_rdata=0x0000_0013.
- Store d_addr=0x100, d_wdata=0xDEADBEEF -> mem_req/mem_we=1 at T+1 with matching addr/data; no d_rvalid; IDLE at T+2.
- if_req and d_req held high, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Fetch accepted, mem_gnt delayed 3 cycles, if_kill during WAIT_RESP -> mem_* stable for the 3 cycles; no if_rvalid; next request accepted afterward.
- rst_n low during WAIT_RESP -> all outputs 0 immediately; a subsequent mem_rvalid is ignored; state IDLE.
- Load at d_addr=0x200 with mem_rvalid delayed 5 cycles -> d_rvalid single pulse one cycle after mem_rvalid; if_ready held 0 throughout.
